// File: rtl/simmem_pkg.sv
// Shared types and width helpers for the simulated memory controller response path.
package simmem_pkg;

    typedef enum logic {
        READ_DATA  = 1'b0,
        WRITE_RESP = 1'b1
    } simmem_resp_channel_e;

    // A single slot still needs a one-bit pointer so array ports stay legal.
    function automatic int unsigned ptr_width(input int unsigned capacity);
        return (capacity > 1) ? $clog2(capacity) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned capacity);
        return $clog2(capacity + 1);
    endfunction

endpackage

// File: rtl/simmem_prio_enc.sv
// Lowest-index-first priority encoder with a found flag.
module simmem_prio_enc #(
    parameter int unsigned Width = 4,
    localparam int unsigned IdxW = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0] req_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             found_o
);

    // Scanning downwards lets the lowest set bit win the last assignment.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = Width - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IdxW'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/simmem_linkedlist_bank.sv
// Response bank: beats share a slot pool, each AXI ID keeps its own linked list so
// per-ID order holds; a beat leaves only when its ID is enabled by the releaser.
module simmem_linkedlist_bank
    import simmem_pkg::*;
#(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned Capacity  = 16,
    parameter int unsigned IDWidth   = 4,
    localparam int unsigned NumIds   = 2 ** IDWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumIds-1:0]    release_en_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [IDWidth-1:0]   in_id_i,
    input  logic [DataWidth-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [IDWidth-1:0]   out_id_o,
    output logic [DataWidth-1:0] out_data_o,
    output logic [NumIds-1:0]    id_nonempty_o
);

    localparam int unsigned PtrW = ptr_width(Capacity);
    localparam int unsigned CntW = cnt_width(Capacity);

    logic [DataWidth-1:0] data_q [Capacity];
    logic [DataWidth-1:0] data_d [Capacity];
    logic [PtrW-1:0]      next_q [Capacity];
    logic [PtrW-1:0]      next_d [Capacity];
    logic [Capacity-1:0]  slot_valid_q, slot_valid_d;
    logic [PtrW-1:0]      head_q [NumIds];
    logic [PtrW-1:0]      head_d [NumIds];
    logic [PtrW-1:0]      tail_q [NumIds];
    logic [PtrW-1:0]      tail_d [NumIds];
    logic [CntW-1:0]      count_q [NumIds];
    logic [CntW-1:0]      count_d [NumIds];
    logic                 lock_q, lock_d;
    logic [IDWidth-1:0]   lock_id_q, lock_id_d;

    logic [PtrW-1:0]    free_idx;
    logic               free_found;
    logic [NumIds-1:0]  rel_req;
    logic [IDWidth-1:0] rel_id;
    logic               rel_found;
    logic [IDWidth-1:0] sel_id;
    logic [PtrW-1:0]    sel_head;
    logic               push, pop;

    simmem_prio_enc #(.Width(Capacity)) i_free_enc (
        .req_i   (~slot_valid_q),
        .idx_o   (free_idx),
        .found_o (free_found)
    );

    always_comb begin
        for (int i = 0; i < NumIds; i++) begin
            rel_req[i]       = release_en_i[i] && (count_q[i] != '0);
            id_nonempty_o[i] = (count_q[i] != '0);
        end
    end

    simmem_prio_enc #(.Width(NumIds)) i_rel_enc (
        .req_i   (rel_req),
        .idx_o   (rel_id),
        .found_o (rel_found)
    );

    // A held beat keeps the output even if its release permission is withdrawn.
    assign sel_id      = lock_q ? lock_id_q : rel_id;
    assign sel_head    = head_q[sel_id];
    assign out_valid_o = lock_q || rel_found;
    assign out_id_o    = sel_id;
    assign out_data_o  = data_q[sel_head];
    assign in_ready_o  = free_found;

    assign push = in_valid_i && free_found;
    assign pop  = out_valid_o && out_ready_i;

    always_comb begin
        data_d       = data_q;
        next_d       = next_q;
        slot_valid_d = slot_valid_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        lock_d       = lock_q;
        lock_id_d    = lock_id_q;

        if (pop) begin
            slot_valid_d[sel_head] = 1'b0;
            head_d[sel_id]         = next_q[sel_head];
            count_d[sel_id]        = count_q[sel_id] - CntW'(1);
            lock_d                 = 1'b0;
        end else if (out_valid_o) begin
            lock_d    = 1'b1;
            lock_id_d = sel_id;
        end

        // Uses the post-pop count so a same-ID pop of the last beat restarts the list.
        if (push) begin
            data_d[free_idx]       = in_data_i;
            slot_valid_d[free_idx] = 1'b1;
            if (count_d[in_id_i] == '0) begin
                head_d[in_id_i] = free_idx;
            end else begin
                next_d[tail_q[in_id_i]] = free_idx;
            end
            tail_d[in_id_i]  = free_idx;
            count_d[in_id_i] = count_d[in_id_i] + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_valid_q <= '0;
            lock_q       <= 1'b0;
            lock_id_q    <= '0;
            for (int i = 0; i < NumIds; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            slot_valid_q <= slot_valid_d;
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            count_q      <= count_d;
        end
    end

    // Payload and pointers are only meaningful under a valid bit or nonzero count.
    always_ff @(posedge clk_i) begin
        data_q <= data_d;
        next_q <= next_d;
        head_q <= head_d;
        tail_q <= tail_d;
    end

`ifndef SYNTHESIS
    int unsigned cnt_sum;
    logic        cnt_ovf;

    always_comb begin
        cnt_sum = 0;
        cnt_ovf = 1'b0;
        for (int i = 0; i < NumIds; i++) begin
            cnt_sum = cnt_sum + 32'(count_q[i]);
            if (32'(count_q[i]) > Capacity) cnt_ovf = 1'b1;
        end
    end

    a_cnt_sum: assert property (@(posedge clk_i) disable iff (!rst_ni)
        cnt_sum == 32'($countones(slot_valid_q)));
    a_cnt_max: assert property (@(posedge clk_i) disable iff (!rst_ni) !cnt_ovf);
    a_head_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_valid_o |-> slot_valid_q[sel_head]);
    a_out_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_valid_o && !out_ready_i |=> out_valid_o && $stable(out_id_o) && $stable(out_data_o));
`endif

endmodule

// File: tb/tb_simmem_linkedlist_bank.sv
// Randomised and directed bench for simmem_linkedlist_bank against a queue-based model.
module tb_simmem_linkedlist_bank;

    localparam int DW  = 16;
    localparam int CAP = 16;
    localparam int IDW = 4;
    localparam int NID = 16;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic [NID-1:0] release_en_i = '0;
    logic           in_valid_i = 1'b0;
    logic           in_ready_o;
    logic [IDW-1:0] in_id_i = '0;
    logic [DW-1:0]  in_data_i = '0;
    logic           out_valid_o;
    logic           out_ready_i = 1'b0;
    logic [IDW-1:0] out_id_o;
    logic [DW-1:0]  out_data_o;
    logic [NID-1:0] id_nonempty_o;

    int total = 0;
    int bad   = 0;

    // Reference model: per-ID FIFOs of payloads and of the slot each beat occupies.
    logic [DW-1:0] mq [NID][$];
    int            ms [NID][$];
    bit            mused [CAP];
    bit            mlock;
    int            mlock_id;

    simmem_linkedlist_bank #(.DataWidth(DW), .Capacity(CAP), .IDWidth(IDW)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .release_en_i  (release_en_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_id_i       (in_id_i),
        .in_data_i     (in_data_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_id_o      (out_id_o),
        .out_data_o    (out_data_o),
        .id_nonempty_o (id_nonempty_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int m_sel(input logic [NID-1:0] en);
        if (mlock) return mlock_id;
        for (int i = 0; i < NID; i++) if (mq[i].size() > 0 && en[i]) return i;
        return -1;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < CAP; i++) if (!mused[i]) return i;
        return -1;
    endfunction

    function automatic logic [NID-1:0] m_nonempty();
        logic [NID-1:0] r;
        for (int i = 0; i < NID; i++) r[i] = (mq[i].size() > 0);
        return r;
    endfunction

    function automatic int m_total();
        int n = 0;
        for (int i = 0; i < NID; i++) n += mq[i].size();
        return n;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NID; i++) begin
            mq[i].delete();
            ms[i].delete();
        end
        for (int i = 0; i < CAP; i++) mused[i] = 1'b0;
        mlock = 1'b0;
        mlock_id = 0;
    endtask

    task automatic drive(input logic v, input logic [IDW-1:0] id, input logic [DW-1:0] d,
                         input logic rdy, input logic [NID-1:0] en);
        in_valid_i   = v;
        in_id_i      = id;
        in_data_i    = d;
        out_ready_i  = rdy;
        release_en_i = en;
        #1;
    endtask

    // Advances one clock; the model decides handshakes from its own state.
    task automatic edge_step();
        int sel, fr, s;
        bit pop, push;
        sel  = m_sel(release_en_i);
        fr   = m_free();
        pop  = (sel >= 0) && out_ready_i;
        push = in_valid_i && (fr >= 0);
        @(posedge clk_i);
        if (pop) begin
            s = ms[sel].pop_front();
            mq[sel].delete(0);
            mused[s] = 1'b0;
            mlock = 1'b0;
        end else if (sel >= 0) begin
            mlock = 1'b1;
            mlock_id = sel;
        end
        if (push) begin
            mq[in_id_i].push_back(in_data_i);
            ms[in_id_i].push_back(fr);
            mused[fr] = 1'b1;
        end
        @(negedge clk_i);
    endtask

    task automatic push_beat(input logic [IDW-1:0] id, input logic [DW-1:0] d);
        drive(1'b1, id, d, 1'b0, '0);
        edge_step();
    endtask

    task automatic drain();
        int e;
        for (int k = 0; k < 64 && m_total() > 0; k++) begin
            drive(1'b0, '0, '0, 1'b1, '1);
            e = m_sel(release_en_i);
            total++;
            if (out_valid_o !== 1'b1 || out_id_o !== IDW'(e) || out_data_o !== mq[e][0]) begin
                bad++;
                $display("FAIL drain: got v=%b id=%0d d=%h, need v=1 id=%0d d=%h",
                         out_valid_o, out_id_o, out_data_o, e, mq[e][0]);
            end
            edge_step();
        end
        drive(1'b0, '0, '0, 1'b1, '1);
        total++;
        if (out_valid_o !== 1'b0 || m_total() != 0) begin
            bad++;
            $display("FAIL drain_end: got v=%b left=%0d, need v=0 left=0", out_valid_o, m_total());
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        m_reset();
        drive(1'b0, '0, '0, 1'b0, '0);
        total++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || id_nonempty_o !== '0) begin
            bad++;
            $display("FAIL reset_active: got v=%b rdy=%b ne=%h, need 0 1 0000",
                     out_valid_o, in_ready_o, id_nonempty_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        total++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || id_nonempty_o !== '0) begin
            bad++;
            $display("FAIL reset_release: got v=%b rdy=%b ne=%h, need 0 1 0000",
                     out_valid_o, in_ready_o, id_nonempty_o);
        end
    endtask

    task automatic test_single_id();
        logic [DW-1:0] exp_d [3] = '{16'h00A1, 16'h00A2, 16'h00A3};
        for (int k = 0; k < 3; k++) push_beat(4'd3, exp_d[k]);
        drive(1'b0, '0, '0, 1'b1, '0);
        total++;
        if (out_valid_o !== 1'b0 || id_nonempty_o !== 16'h0008) begin
            bad++;
            $display("FAIL hold_disabled: got v=%b ne=%h, need v=0 ne=0008", out_valid_o, id_nonempty_o);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, '0, 1'b1, 16'h0008);
            total++;
            if (out_valid_o !== 1'b1 || out_data_o !== exp_d[k]) begin
                bad++;
                $display("FAIL id3_order[%0d]: got v=%b d=%h, need v=1 d=%h", k, out_valid_o, out_data_o, exp_d[k]);
            end
            edge_step();
        end
        drive(1'b0, '0, '0, 1'b1, 16'h0008);
        total++;
        if (out_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL id3_empty: got v=%b, need 0", out_valid_o);
        end
    endtask

    task automatic test_priority();
        logic [DW-1:0]  exp_d [3] = '{16'h0010, 16'h0011, 16'h0020};
        logic [IDW-1:0] exp_i [3] = '{4'd1, 4'd1, 4'd2};
        push_beat(4'd1, 16'h0010);
        push_beat(4'd2, 16'h0020);
        push_beat(4'd1, 16'h0011);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, '0, 1'b1, '1);
            total++;
            if (out_valid_o !== 1'b1 || out_id_o !== exp_i[k] || out_data_o !== exp_d[k]) begin
                bad++;
                $display("FAIL priority[%0d]: got v=%b id=%0d d=%h, need v=1 id=%0d d=%h",
                         k, out_valid_o, out_id_o, out_data_o, exp_i[k], exp_d[k]);
            end
            edge_step();
        end
    endtask

    task automatic test_full();
        int e, freed;
        logic [3:0] expp;
        for (int k = 0; k < CAP; k++) push_beat(IDW'($urandom_range(0, NID-1)), DW'($urandom));
        drive(1'b1, 4'd9, 16'hDEAD, 1'b0, '0);
        total++;
        if (in_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL full_ready: got %b, need 0", in_ready_o);
        end
        edge_step();
        drive(1'b0, '0, '0, 1'b0, '0);
        total++;
        if (id_nonempty_o !== m_nonempty() || dut.slot_valid_q !== 16'hFFFF || in_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL full_drop: got ne=%h sv=%h rdy=%b, need ne=%h sv=ffff rdy=0",
                     id_nonempty_o, dut.slot_valid_q, in_ready_o, m_nonempty());
        end
        drive(1'b0, '0, '0, 1'b1, '1);
        e = m_sel(release_en_i);
        freed = ms[e][0];
        total++;
        if (out_valid_o !== 1'b1 || out_data_o !== mq[e][0]) begin
            bad++;
            $display("FAIL full_release: got v=%b d=%h, need v=1 d=%h", out_valid_o, out_data_o, mq[e][0]);
        end
        edge_step();
        drive(1'b1, 4'd12, 16'hBEEF, 1'b0, '0);
        total++;
        if (in_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL full_reopen: got %b, need 1", in_ready_o);
        end
        edge_step();
        expp = 4'(freed);
        total++;
        if (dut.tail_q[12] !== expp) begin
            bad++;
            $display("FAIL full_slot: got %0d, need %0d", dut.tail_q[12], expp);
        end
        drain();
    endtask

    task automatic test_lock();
        push_beat(4'd5, 16'h0055);
        push_beat(4'd0, 16'h0005);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, '0, (k == 3), (k == 0) ? 16'h0020 : 16'h0001);
            total++;
            if (out_valid_o !== 1'b1 || out_id_o !== 4'd5 || out_data_o !== 16'h0055) begin
                bad++;
                $display("FAIL lock_hold[%0d]: got v=%b id=%0d d=%h, need v=1 id=5 d=0055",
                         k, out_valid_o, out_id_o, out_data_o);
            end
            edge_step();
        end
        drive(1'b0, '0, '0, 1'b1, 16'h0001);
        total++;
        if (out_valid_o !== 1'b1 || out_id_o !== 4'd0 || out_data_o !== 16'h0005) begin
            bad++;
            $display("FAIL lock_next: got v=%b id=%0d d=%h, need v=1 id=0 d=0005",
                     out_valid_o, out_id_o, out_data_o);
        end
        edge_step();
        drain();
    endtask

    task automatic test_same_id();
        logic [3:0] expp;
        push_beat(4'd7, 16'h0070);
        drive(1'b1, 4'd7, 16'h0071, 1'b1, 16'h0080);
        total++;
        if (out_valid_o !== 1'b1 || out_data_o !== 16'h0070) begin
            bad++;
            $display("FAIL same_pop: got v=%b d=%h, need v=1 d=0070", out_valid_o, out_data_o);
        end
        edge_step();
        drive(1'b0, '0, '0, 1'b0, 16'h0080);
        expp = 4'(ms[7][0]);
        total++;
        if (out_valid_o !== 1'b1 || out_data_o !== 16'h0071 || dut.count_q[7] !== 5'd1 ||
            dut.head_q[7] !== expp || dut.tail_q[7] !== expp) begin
            bad++;
            $display("FAIL same_push: got v=%b d=%h cnt=%0d h=%0d t=%0d, need v=1 d=0071 cnt=1 h=t=%0d",
                     out_valid_o, out_data_o, dut.count_q[7], dut.head_q[7], dut.tail_q[7], expp);
        end
        edge_step();
        drain();
    endtask

    task automatic test_random();
        int e;
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 2) != 0, IDW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3)),
                  DW'($urandom), $urandom_range(0, 2) == 0, NID'($urandom & $urandom));
            e = m_sel(release_en_i);
            total++;
            if (in_ready_o !== (m_free() >= 0) || out_valid_o !== (e >= 0) || id_nonempty_o !== m_nonempty()) begin
                bad++;
                $display("FAIL rand_ctl[%0d]: got rdy=%b v=%b ne=%h, need rdy=%b v=%b ne=%h", c,
                         in_ready_o, out_valid_o, id_nonempty_o, m_free() >= 0, e >= 0, m_nonempty());
            end
            if (e >= 0) begin
                total++;
                if (out_id_o !== IDW'(e) || out_data_o !== mq[e][0]) begin
                    bad++;
                    $display("FAIL rand_out[%0d]: got id=%0d d=%h, need id=%0d d=%h",
                             c, out_id_o, out_data_o, e, mq[e][0]);
                end
            end
            edge_step();
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic [3:0] expp;
        for (int k = 0; k < 6; k++) push_beat(IDW'($urandom_range(0, NID-1)), DW'($urandom));
        drive(1'b0, '0, '0, 1'b0, '1);
        rst_ni = 1'b0;
        #1;
        m_reset();
        total++;
        if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || id_nonempty_o !== '0) begin
            bad++;
            $display("FAIL reset_mid: got v=%b rdy=%b ne=%h, need 0 1 0000", out_valid_o, in_ready_o, id_nonempty_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        push_beat(4'd4, 16'h0444);
        expp = 4'(ms[4][0]);
        total++;
        if (dut.tail_q[4] !== expp || dut.slot_valid_q !== 16'h0001 || id_nonempty_o !== 16'h0010) begin
            bad++;
            $display("FAIL reset_alloc: got t=%0d sv=%h ne=%h, need t=%0d sv=0001 ne=0010",
                     dut.tail_q[4], dut.slot_valid_q, id_nonempty_o, expp);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        @(negedge clk_i);
        test_reset();
        test_single_id();
        test_priority();
        test_full();
        test_lock();
        test_same_id();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
